// File: rtl/pool_wr_packer.sv
// Pooling write packer: packs 8-bit pooled results into 32-byte
// lines and writes each line to the result buffer.
// Ports: sw_* job setup, res_* result stream, mem_* line write,
// busy/done status.
module pool_wr_packer #(
  parameter int ADDR_WIDTH        = 19,
  parameter int WORD_WIDTH        = 8,
  parameter int NUM_WORDS_IN_LINE = 32,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_go,
  input  logic [ADDR_WIDTH-1:0] sw_addr_z,
  input  logic [CNT_WIDTH-1:0]  sw_res_num,
  input  logic                  res_valid,
  input  logic [WORD_WIDTH-1:0] res_data,
  output logic                  res_ready,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_start_addr,
  output logic [NUM_WORDS_IN_LINE-1:0][WORD_WIDTH-1:0] mem_data,
  output logic [$clog2(NUM_WORDS_IN_LINE)-1:0] mem_last_valid,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = $clog2(NUM_WORDS_IN_LINE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_line_addr;
  logic [CNT_WIDTH-1:0]  r_rem;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_last;
  logic [NUM_WORDS_IN_LINE-1:0][WORD_WIDTH-1:0] r_buf;
  logic                  r_ready;
  logic                  r_req;
  logic                  r_busy;
  logic                  r_done;

  logic w_acc;
  logic w_line_full;
  logic w_last_res;

  assign w_acc       = res_valid & r_ready;
  assign w_line_full = (r_idx == IDX_W'(NUM_WORDS_IN_LINE - 1));
  assign w_last_res  = (r_rem == CNT_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_line_addr <= '0;
      r_rem       <= '0;
      r_idx       <= '0;
      r_last      <= '0;
      r_buf       <= '0;
      r_ready     <= 1'b0;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sw_go) begin
            r_line_addr <= sw_addr_z;
            r_rem       <= sw_res_num;
            r_idx       <= '0;
            r_buf       <= '0;
            if (sw_res_num == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FILL;
              r_ready <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (w_acc) begin
            r_buf[r_idx] <= res_data;
            // wraps to 0 on a full line, ready for the next one
            r_idx <= r_idx + IDX_W'(1);
            if (r_rem != '0) begin
              r_rem <= r_rem - CNT_WIDTH'(1);
            end
            if (w_line_full || w_last_res) begin
              r_state <= S_WRITE;
              r_ready <= 1'b0;
              r_req   <= 1'b1;
              r_last  <= r_idx;
            end
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            r_req       <= 1'b0;
            r_line_addr <= r_line_addr +
                           ADDR_WIDTH'(NUM_WORDS_IN_LINE);
            r_idx       <= '0;
            r_buf       <= '0;
            if (r_rem == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FILL;
              r_ready <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // a held-high go must not relaunch the job
          if (!sw_go) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign res_ready      = r_ready;
  assign mem_req        = r_req;
  assign mem_start_addr = r_line_addr;
  assign mem_data       = r_buf;
  assign mem_last_valid = r_last;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule

// File: doc/pool_wr_packer.md
# pool_wr_packer

Downstream stage of the pooling unit. It accepts the stream of 8-bit pooled results (one per window), packs them into 32-byte memory lines and writes each line to the result buffer through the write-memory handshake. Lines start at the software-programmed return address and advance sequentially. It frees the pool core from memory-write stalls and handles the partial final line.

## Interface
Parameters:
- ADDR_WIDTH, 19, memory byte-address width
- WORD_WIDTH, 8, bits per memory word (one pooled result)
- NUM_WORDS_IN_LINE, 32, words per memory line
- CNT_WIDTH, 16, width of the result counter

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- sw_go  in  1  start level from software
- sw_addr_z  in  ADDR_WIDTH  first byte address of the result region, sampled at start
- sw_res_num  in  CNT_WIDTH  total results to store, sampled at start
- res_valid  in  1  pooled result valid
- res_data  in  WORD_WIDTH  pooled result byte
- res_ready  out  1  packer can accept a result
- mem_req  out  1  line-write request
- mem_start_addr  out  ADDR_WIDTH  line byte address
- mem_data  out  [NUM_WORDS_IN_LINE-1:0][WORD_WIDTH-1:0]  line payload; byte 0 is at mem_start_addr
- mem_last_valid  out  $clog2(NUM_WORDS_IN_LINE)  index of the last valid byte in the line
- mem_ack  in  1  memory accepted the line
- busy  out  1  job in progress
- done  out  1  job complete

## Operation
States: IDLE, FILL, WRITE, DONE.
- **IDLE**
  - sw_go=1: latch sw_addr_z into line_addr and sw_res_num into remaining.
  - Clear byte index idx, and clear the line buffer to zero.
  - Go to FILL, or to DONE if sw_res_num=0.
- **FILL**
  - res_ready=1.
  - On res_valid&&res_ready: buffer[idx]<=res_data, idx++, remaining--.
  - If that byte makes idx reach NUM_WORDS_IN_LINE, or makes remaining reach 0, go to WRITE.
- **WRITE**
  - res_ready=0, mem_req=1.
  - mem_start_addr=line_addr.
  - mem_last_valid=(bytes in line)-1.
  - mem_data=buffer; unwritten bytes read 0.
  - All outputs stay stable until mem_ack=1 is sampled. On that edge:
    - line_addr+=NUM_WORDS_IN_LINE.
    - Clear idx and the buffer.
    - Go to DONE if remaining=0, else to FILL.
- **DONE**
  - done=1.
  - Hold while sw_go=1; return to IDLE when sw_go=0. A held-high sw_go never restarts a job.

Status outputs:
- busy=1 in FILL and WRITE.
- done=1 only in DONE.

Arithmetic:
- line_addr wraps modulo 2^ADDR_WIDTH.
- remaining is unsigned and never decremented below 0.
- res_data is stored unmodified.

## Timing
- Reset values:
  - res_ready=0, mem_req=0, mem_start_addr=0, mem_data=0, mem_last_valid=0.
  - busy=0, done=0, state=IDLE.
- Reset mid-job aborts immediately; buffered bytes are discarded and no partial write is issued.
- Start: sw_go sampled high in IDLE at edge N gives res_ready=1 from cycle N+1.
- Line latency: last byte of a line accepted at edge N gives mem_req=1 in cycle N+1.
- mem_ack:
  - mem_ack=1 sampled at edge M (mem_req high) gives mem_req=0 from M+1.
  - res_ready=1 from M+1 if more results remain.
  - mem_ack is ignored outside WRITE.
- Each line costs at least one bubble cycle on res_ready; backpressure lasts for the whole of WRITE.
- Job end: done=1 from the cycle after the final mem_ack. With sw_res_num=0, done=1 in the cycle after start and no mem_req is issued.
- Total lines per job = ceil(sw_res_num/NUM_WORDS_IN_LINE).

## Test plan
- **Two full lines:** sw_res_num=64, sw_addr_z=0x100, results 0..63 streamed back-to-back, mem_ack one cycle after mem_req.
  - Line 1: addr 0x100, bytes 0..31, last_valid=31.
  - Line 2: addr 0x120, bytes 32..63, last_valid=31.
  - Then done=1.
- **Partial tail:** sw_res_num=40.
  - Line 2: addr base+32, bytes 0..7 = results 32..39, bytes 8..31 = 0, last_valid=7.
- **Delayed ack:** mem_ack held off 5 cycles.
  - mem_req, addr and data stable for all 6 cycles.
  - res_ready=0 throughout; no result lost or duplicated.
- **Empty job:** sw_res_num=0.
  - busy never asserted, done=1 one cycle after start, zero mem_req pulses.
- **Reset mid-job:** assert rst_n=0 after 20 results accepted.
  - All outputs return to reset values at once.
  - A new job of 32 results writes one line at the new sw_addr_z.
- **Full pool layer with go held:** sw_go held high, sw_res_num=14641 (121×121 results).
  - 458 lines; last line has last_valid=16.
  - Byte-exact against the golden results file.
  - done stays 1 and no second job starts until sw_go drops.
